// File: rtl/imm_extend_pipe.sv
// Registered immediate generator for decode: RV32I/RV64I I/B/S/U/J, shamt and CSR zimm formats, with tag passthrough.
// Latency: 1 cycle from accept to out_valid_o when the output register is free or draining.
// Backpressure: 2-entry skid (output + skid register), in_ready_o registered; flush_i drops both entries.
// Optional: define IMM_EXTEND_ERR_CHECK_EN to flag ImmSrc_i=111 on ImmErr_o (otherwise ImmErr_o is tied low).
module imm_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            ImmSrc_i,
    input  logic [31:0]           ImmInstr_i,
    input  logic [TAG_WIDTH-1:0]  Tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] ImmExt_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic                  ImmErr_o
);

    logic [31:0]           raw32_c;
    logic                  sext_c;
    logic [DATA_WIDTH-1:0] imm_c;
    logic [5:0]            shamt_c;
    logic                  unused_opcode;

    // Opcode bits never feed an immediate.
    assign unused_opcode = ^ImmInstr_i[6:0];

    logic                  or_vld_q, or_vld_d;
    logic                  sr_vld_q, sr_vld_d;
    logic                  rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0] or_imm_q, or_imm_d, sr_imm_q, sr_imm_d;
    logic [TAG_WIDTH-1:0]  or_tag_q, or_tag_d, sr_tag_q, sr_tag_d;
    logic                  accept_c, consume_c;

`ifdef IMM_EXTEND_ERR_CHECK_EN
    logic err_c;
    logic or_err_q, or_err_d, sr_err_q, sr_err_d;
`endif

    // Decode the format into a 32-bit value, then sign- or zero-extend to XLEN.
    always_comb begin
        shamt_c = {(DATA_WIDTH == 64) ? ImmInstr_i[25] : 1'b0, ImmInstr_i[24:20]};
        raw32_c = '0;
        sext_c  = 1'b1;
        case (ImmSrc_i)
            3'b000: raw32_c = {{20{ImmInstr_i[31]}}, ImmInstr_i[31:20]};
            3'b001: raw32_c = {{20{ImmInstr_i[31]}}, ImmInstr_i[7], ImmInstr_i[30:25],
                               ImmInstr_i[11:8], 1'b0};
            3'b010: raw32_c = {{20{ImmInstr_i[31]}}, ImmInstr_i[31:25], ImmInstr_i[11:7]};
            3'b011: raw32_c = {ImmInstr_i[31:12], 12'b0};
            3'b100: raw32_c = {{12{ImmInstr_i[31]}}, ImmInstr_i[19:12], ImmInstr_i[20],
                               ImmInstr_i[30:21], 1'b0};
            3'b101: begin
                raw32_c = {26'b0, shamt_c};
                sext_c  = 1'b0;
            end
            3'b110: begin
                raw32_c = {27'b0, ImmInstr_i[19:15]};
                sext_c  = 1'b0;
            end
            default: begin
                raw32_c = '0;
                sext_c  = 1'b0;
            end
        endcase
        imm_c = sext_c ? DATA_WIDTH'($signed(raw32_c)) : DATA_WIDTH'(raw32_c);
    end

`ifdef IMM_EXTEND_ERR_CHECK_EN
    assign err_c = (ImmSrc_i == 3'b111);
`endif

    assign accept_c  = in_valid_i && rdy_q;
    assign consume_c = or_vld_q && out_ready_i;

    // Skid steering: SR refills OR on consume, otherwise new beats fill OR first, then SR.
    always_comb begin
        or_vld_d = or_vld_q;
        sr_vld_d = sr_vld_q;
        or_imm_d = or_imm_q;
        or_tag_d = or_tag_q;
        sr_imm_d = sr_imm_q;
        sr_tag_d = sr_tag_q;
`ifdef IMM_EXTEND_ERR_CHECK_EN
        or_err_d = or_err_q;
        sr_err_d = sr_err_q;
`endif
        if (flush_i) begin
            // Data registers keep their contents; only the valids drop.
            or_vld_d = 1'b0;
            sr_vld_d = 1'b0;
        end else if (consume_c && sr_vld_q) begin
            or_vld_d = 1'b1;
            or_imm_d = sr_imm_q;
            or_tag_d = sr_tag_q;
`ifdef IMM_EXTEND_ERR_CHECK_EN
            or_err_d = sr_err_q;
`endif
            sr_vld_d = accept_c;
            if (accept_c) begin
                sr_imm_d = imm_c;
                sr_tag_d = Tag_i;
`ifdef IMM_EXTEND_ERR_CHECK_EN
                sr_err_d = err_c;
`endif
            end
        end else if (!or_vld_q || consume_c) begin
            or_vld_d = accept_c;
            if (accept_c) begin
                or_imm_d = imm_c;
                or_tag_d = Tag_i;
`ifdef IMM_EXTEND_ERR_CHECK_EN
                or_err_d = err_c;
`endif
            end
        end else if (accept_c) begin
            sr_vld_d = 1'b1;
            sr_imm_d = imm_c;
            sr_tag_d = Tag_i;
`ifdef IMM_EXTEND_ERR_CHECK_EN
            sr_err_d = err_c;
`endif
        end
        // Ready is registered so out_ready_i never reaches in_ready_o combinationally.
        rdy_d = !sr_vld_d;
    end

    // State registers; reset drops both entries and holds in_ready_o low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            or_vld_q <= 1'b0;
            sr_vld_q <= 1'b0;
            rdy_q    <= 1'b0;
            or_imm_q <= '0;
            or_tag_q <= '0;
            sr_imm_q <= '0;
            sr_tag_q <= '0;
`ifdef IMM_EXTEND_ERR_CHECK_EN
            or_err_q <= 1'b0;
            sr_err_q <= 1'b0;
`endif
        end else begin
            or_vld_q <= or_vld_d;
            sr_vld_q <= sr_vld_d;
            rdy_q    <= rdy_d;
            or_imm_q <= or_imm_d;
            or_tag_q <= or_tag_d;
            sr_imm_q <= sr_imm_d;
            sr_tag_q <= sr_tag_d;
`ifdef IMM_EXTEND_ERR_CHECK_EN
            or_err_q <= or_err_d;
            sr_err_q <= sr_err_d;
`endif
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = or_vld_q;
    assign ImmExt_o    = or_imm_q;
    assign Tag_o       = or_tag_q;
`ifdef IMM_EXTEND_ERR_CHECK_EN
    assign ImmErr_o    = or_err_q;
`else
    assign ImmErr_o    = 1'b0;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: 32- and 64-bit instances share stimulus; scoreboard queues checked by per-instance monitors.
// Latency: expected beats are pushed on accept and popped on each output handshake.
// Backpressure: exercises skid fill, ready drop, flush and mid-stream async reset.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  src = '0;
    logic [31:0] instr = '0;
    logic [4:0]  tag = '0;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int total = 0;
    int bad   = 0;

`ifdef IMM_EXTEND_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .ImmSrc_i(src), .ImmInstr_i(instr), .Tag_i(tag),
        .out_valid_o(out_valid32), .out_ready_i(out_ready),
        .ImmExt_o(imm32), .Tag_o(tag32), .ImmErr_o(err32)
    );

    imm_extend_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready64),
        .ImmSrc_i(src), .ImmInstr_i(instr), .Tag_i(tag),
        .out_valid_o(out_valid64), .out_ready_i(out_ready),
        .ImmExt_o(imm64), .Tag_o(tag64), .ImmErr_o(err64)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid32 && out_ready) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon32_unexpected: got tag=%0d want no beat", tag32);
            end else begin
                e = q32.pop_front();
                chk("mon32_imm", {32'b0, imm32}, {32'b0, e.e32});
                chk("mon32_tag", {59'b0, tag32}, {59'b0, e.tag});
                chk("mon32_err", {63'b0, err32}, {63'b0, e.err});
            end
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid64 && out_ready) begin
            if (q64.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon64_unexpected: got tag=%0d want no beat", tag64);
            end else begin
                e = q64.pop_front();
                chk("mon64_imm", imm64, e.e64);
                chk("mon64_tag", {59'b0, tag64}, {59'b0, e.tag});
                chk("mon64_err", {63'b0, err64}, {63'b0, e.err});
            end
        end
    end

    // Present one beat and hold it until accepted (bounded); returns 1ns after the accepting edge.
    task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [4:0] t,
                        input logic [31:0] e32, input logic [63:0] e64, input logic er);
        exp_t e;
        bit   done;
        e.e32 = e32;
        e.e64 = e64;
        e.tag = t;
        e.err = er;
        instr = i;
        src = s;
        tag = t;
        in_valid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready32 && !flush) begin
                q32.push_back(e);
                q64.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: tag=%0d not accepted, want accepted", t);
        end
    endtask

    logic [31:0] v_i   [11];
    logic [2:0]  v_s   [11];
    logic [31:0] v_e32 [11];
    logic [63:0] v_e64 [11];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v_i[0]  = 32'hFFF00093; v_s[0]  = 3'd0; v_e32[0]  = 32'hFFFFFFFF; v_e64[0]  = 64'hFFFFFFFFFFFFFFFF;
        v_i[1]  = 32'hFE000EE3; v_s[1]  = 3'd1; v_e32[1]  = 32'hFFFFFFFC; v_e64[1]  = 64'hFFFFFFFFFFFFFFFC;
        v_i[2]  = 32'h00A12423; v_s[2]  = 3'd2; v_e32[2]  = 32'h00000008; v_e64[2]  = 64'h0000000000000008;
        v_i[3]  = 32'hFE112E23; v_s[3]  = 3'd2; v_e32[3]  = 32'hFFFFFFFC; v_e64[3]  = 64'hFFFFFFFFFFFFFFFC;
        v_i[4]  = 32'h123450B7; v_s[4]  = 3'd3; v_e32[4]  = 32'h12345000; v_e64[4]  = 64'h0000000012345000;
        v_i[5]  = 32'h800000B7; v_s[5]  = 3'd3; v_e32[5]  = 32'h80000000; v_e64[5]  = 64'hFFFFFFFF80000000;
        v_i[6]  = 32'hFF9FF0EF; v_s[6]  = 3'd4; v_e32[6]  = 32'hFFFFFFF8; v_e64[6]  = 64'hFFFFFFFFFFFFFFF8;
        v_i[7]  = 32'h03F01093; v_s[7]  = 3'd5; v_e32[7]  = 32'h0000001F; v_e64[7]  = 64'h000000000000003F;
        v_i[8]  = 32'h000FD073; v_s[8]  = 3'd6; v_e32[8]  = 32'h0000001F; v_e64[8]  = 64'h000000000000001F;
        v_i[9]  = 32'hFFFFFFFF; v_s[9]  = 3'd7; v_e32[9]  = 32'h00000000; v_e64[9]  = 64'h0000000000000000;
        v_i[10] = 32'h7FF00013; v_s[10] = 3'd0; v_e32[10] = 32'h000007FF; v_e64[10] = 64'h00000000000007FF;

        // Reset values while reset is asserted.
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid32", {63'b0, out_valid32}, 64'd0);
        chk("rst_in_ready32",  {63'b0, in_ready32},  64'd0);
        chk("rst_imm32",       {32'b0, imm32},       64'd0);
        chk("rst_tag32",       {59'b0, tag32},       64'd0);
        chk("rst_err32",       {63'b0, err32},       64'd0);
        chk("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
        chk("rst_imm64",       imm64,                64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready_still_low", {63'b0, in_ready32}, 64'd0);
        @(posedge clk);
        #1;
        chk("first_edge_ready32", {63'b0, in_ready32}, 64'd1);
        chk("first_edge_ready64", {63'b0, in_ready64}, 64'd1);

        // Directed formats, back-to-back with out_ready high.
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            send(v_i[k], v_s[k], 5'(k + 1), v_e32[k], v_e64[k], (k == 9) ? ERR_EN : 1'b0);
            if (k == 0) begin
                chk("latency_valid32", {63'b0, out_valid32}, 64'd1);
                chk("latency_imm32",   {32'b0, imm32},       64'h00000000FFFFFFFF);
                chk("latency_tag32",   {59'b0, tag32},       64'd1);
            end
        end
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: fill OR and SR, hold beat 3 at the source, then release.
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 5'd1, 32'd1, 64'd1, 1'b0);
        chk("bp_valid_after_1", {63'b0, out_valid32}, 64'd1);
        chk("bp_ready_after_1", {63'b0, in_ready32},  64'd1);
        send(32'hFFFFFFFF, 3'd7, 5'd2, 32'd0, 64'd0, ERR_EN);
        chk("bp_ready_low32", {63'b0, in_ready32}, 64'd0);
        chk("bp_ready_low64", {63'b0, in_ready64}, 64'd0);
        fork
            send(32'h00300093, 3'd0, 5'd3, 32'd3, 64'd3, 1'b0);
            begin
                repeat (2) @(negedge clk);
                chk("bp_hold_tag32", {59'b0, tag32}, 64'd1);
                chk("bp_hold_imm64", imm64,          64'd1);
                chk("bp_hold_ready", {63'b0, in_ready32}, 64'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Flush with both entries full and a beat presented.
        out_ready = 1'b0;
        send(32'h00400093, 3'd0, 5'd4, 32'd4, 64'd4, 1'b0);
        send(32'h00500093, 3'd0, 5'd5, 32'd5, 64'd5, 1'b0);
        instr = 32'h00600093; src = 3'd0; tag = 5'd6;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        q32.delete();
        q64.delete();
        chk("flush_valid32", {63'b0, out_valid32}, 64'd0);
        chk("flush_valid64", {63'b0, out_valid64}, 64'd0);
        chk("flush_ready32", {63'b0, in_ready32},  64'd1);

        // Flush overriding an accept into an empty pipe.
        instr = 32'h00700093; tag = 5'd7;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_accept_dropped", {63'b0, out_valid32}, 64'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_nothing_emitted", {63'b0, out_valid32}, 64'd0);

        // Asynchronous reset between edges with a beat held in OR.
        out_ready = 1'b0;
        send(32'h00800093, 3'd0, 5'd8, 32'd8, 64'd8, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid32", {63'b0, out_valid32}, 64'd0);
        chk("arst_ready32", {63'b0, in_ready32},  64'd0);
        chk("arst_valid64", {63'b0, out_valid64}, 64'd0);
        chk("arst_imm32",   {32'b0, imm32},       64'd0);
        q32.delete();
        q64.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_recover_ready", {63'b0, in_ready32},  64'd1);
        chk("arst_no_beat",       {63'b0, out_valid32}, 64'd0);

        // One more beat after reset, then drain.
        send(32'hFFF00093, 3'd0, 5'd9, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        for (int n = 0; n < 100 && (q32.size() != 0 || q64.size() != 0); n++)
            @(posedge clk);
        #1;
        chk("drain32_empty", 64'(q32.size()), 64'd0);
        chk("drain64_empty", 64'(q64.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
